zle_xca_dec: RTL and testbench
==============================

// Module: zle_xcA_dec
// PURPOSE
//  Zero run-length decoder; the inverse of the ZLE encoder datapath/FSM pair.
//  - Consumes one token per accepted input: a literal nonzero sample, or a zero-run token carrying count N.
//  - Expands each run token back into N zero samples on the output stream.
//  - Sits on the receive side of a ZLE link, feeding the sample consumer.
//  - Valid/ready streaming on both sides; at most one output sample per cycle.
// PARAMETERS
//  DATA_W  3  sample width; literal field = i_d[DATA_W-1:0]
//  CNT_W   4  run-count field width; max run = 2**CNT_W-1; CNT_W >= DATA_W required
// PORTS
//  clock  in   1         rising-edge clock
//  reset  in   1         asynchronous, active-low reset
//  i_d    in   CNT_W+1   token; i_d[CNT_W]=1 -> run, count N=i_d[CNT_W-1:0]; =0 -> literal
//  i_v    in   1         input token valid
//  i_r    out  1         input ready; token accepted on cycle with i_v&i_r
//  o_d    out  DATA_W    decoded sample (registered)
//  o_v    out  1         output valid (registered)
//  o_r    in   1         downstream ready; sample transferred on o_v&o_r
//  busy   out  1         1 while in RUN state
//  err    out  1         sticky: literal 0 received, or run token with N=0
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=ACCEPT, rem=0, o_v=0, o_d=0, err=0, busy=0; i_r=1 immediately after reset.
//   - Reset mid-run drops the remaining zeros and any pending output.
//  Output register free when adv = !o_v | o_r.
//  State ACCEPT:
//   - i_r = adv.
//   - Literal accepted: o_d<=i_d[DATA_W-1:0], o_v<=1; bits [CNT_W-1:DATA_W] ignored.
//   - Literal value 0 is still emitted and sets err.
//   - Run N>=1 accepted: o_d<=0, o_v<=1, rem<=N-1; next state RUN if N>=2, else stays ACCEPT.
//   - Run N=0 accepted: token consumed, no sample emitted, err<=1; o_v<=0 if o_r.
//   - No accept while adv: o_v<=0. When !adv: all registers hold.
//  State RUN:
//   - i_r=0, busy=1.
//   - On adv: o_d<=0, o_v<=1, rem<=rem-1; when rem==1, next state ACCEPT.
//   - When !adv: hold (backpressure stalls expansion, no sample lost or duplicated).
//  Timing:
//   - Latency: token accepted in cycle t -> first sample valid in cycle t+1.
//   - Run of N emits exactly N zeros on N consecutive adv cycles.
//   - Next token can be accepted in the cycle the last zero is loaded (state already ACCEPT).
//  Full throughput: one sample per cycle when o_r is held 1.
//   - Literals: back-to-back tokens, no bubbles.
//   - Run of N: N cycles per token, no bubble before the next token.
//  Width rules:
//   - rem is CNT_W bits and never underflows (no decrement at 0).
//   - Max run 2**CNT_W-1 (15 at defaults) needs no wrap handling.
//  Simultaneous events:
//   - An accept in the same cycle as o_r drain replaces o_d (pass-through register).
//   - i_v is ignored while i_r=0; upstream must hold the token stable.
//  err: sticky, cleared only by reset; does not alter data flow.
// TESTING
//  1 Reset then literals 3,5,7 with o_r=1 -> o_d 3,5,7 in consecutive cycles, o_v=1 from cycle after first accept.
//  2 Run token 0x13 (N=3) then literal 2 -> o_d 0,0,0,2; i_r=0 for 2 cycles; busy=1 for 2 cycles.
//  3 Run N=15 with o_r toggling 1,0,1,0 -> exactly 15 zeros transferred, none lost or duplicated, no accept until done.
//  4 Run N=1 then run N=0 then literal 4 -> outputs 0,4; err=1 after N=0 token; data flow unaffected.
//  5 Assert reset low mid-run (rem=7) -> o_v=0, busy=0, i_r=1 next cycle; new literal 6 decodes normally.
//  6 Random token stream vs encoder model, random o_r -> output equals original sample stream (scoreboard).

Source files
------------

// File: rtl/zle_xca_dec.sv
// Zero run-length decoder: expands run tokens into zero samples and passes literals through.
// Valid/ready on both sides, one registered output sample per cycle.
module zle_xca_dec #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W:0]    i_d,
    input  logic              i_v,
    output logic              i_r,
    output logic [DATA_W-1:0] o_d,
    output logic              o_v,
    input  logic              o_r,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        ST_ACCEPT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              adv;
    logic              is_run;
    logic [CNT_W-1:0]  run_n;
    logic [DATA_W-1:0] lit;

    // The output register may be reloaded when empty or being drained this cycle.
    assign adv    = !valid_q | o_r;
    assign is_run = i_d[CNT_W];
    assign run_n  = i_d[CNT_W-1:0];
    assign lit    = i_d[DATA_W-1:0];

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        i_r     = 1'b0;
        busy    = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                i_r = adv;
                if (adv) begin
                    valid_d = 1'b0;
                    if (i_v) begin
                        if (is_run) begin
                            if (run_n == '0) begin
                                err_d = 1'b1;
                            end else begin
                                data_d  = '0;
                                valid_d = 1'b1;
                                rem_d   = run_n - CNT_W'(1);
                                if (run_n > CNT_W'(1)) begin
                                    state_d = ST_RUN;
                                end
                            end
                        end else begin
                            data_d  = lit;
                            valid_d = 1'b1;
                            if (lit == '0) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_RUN: begin
                busy = 1'b1;
                if (adv) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    // Guarded decrement: rem never wraps below zero.
                    if (rem_q != '0) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACCEPT;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_d = data_q;
    assign o_v = valid_q;
    assign err = err_q;

endmodule

// File: tb/tb_zle_xca_dec.sv
// Directed and scoreboard bench for the zero run-length decoder.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
module tb_zle_xca_dec;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [CNT_W:0]    i_d   = '0;
    logic              i_v   = 1'b0;
    logic              i_r;
    logic [DATA_W-1:0] o_d;
    logic              o_v;
    logic              o_r   = 1'b1;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int or_mode = 0;   // 0: o_r=1, 1: toggle, 2: random
    int last_acc = 0;

    logic [DATA_W-1:0] got_q[$];
    int                got_cyc[$];
    int                busy_cnt = 0;
    int                ir_low_cnt = 0;
    int                overlap_cnt = 0;

    zle_xca_dec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .i_d  (i_d),
        .i_v  (i_v),
        .i_r  (i_r),
        .o_d  (o_d),
        .o_v  (o_v),
        .o_r  (o_r),
        .busy (busy),
        .err  (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin : or_drive
        forever begin
            @(posedge clock);
            #1;
            case (or_mode)
                1:       o_r = ~o_r;
                2:       o_r = ($urandom_range(0, 3) != 0);
                default: o_r = 1'b1;
            endcase
        end
    end

    // Transfer monitor: every o_v&o_r handshake is recorded with its cycle stamp.
    always @(negedge clock) begin
        if (reset) begin
            if (o_v && o_r) begin
                got_q.push_back(o_d);
                got_cyc.push_back(cyc);
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            if (!i_r) ir_low_cnt <= ir_low_cnt + 1;
            if (busy && i_r) overlap_cnt <= overlap_cnt + 1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [CNT_W:0] tok);
        int  waited = 0;
        bit  done = 0;
        i_d = tok;
        i_v = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (i_r) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: token %h not accepted after %0d cycles", tok, waited);
                    done = 1;
                end
            end
            @(posedge clock);
            #1;
        end
        last_acc = cyc;
        i_v = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        repeat (4) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_v   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_o_v: got %b expected 0", o_v); end
        checks++; if (o_d !== 3'd0) begin errors++; $display("FAIL reset_o_d: got %0d expected 0", o_d); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL reset_i_r: got %b expected 1", i_r); end
    endtask

    task automatic test_literals();
        int base = got_q.size();
        int first;
        logic [DATA_W-1:0] exp [3] = '{3'd3, 3'd5, 3'd7};
        or_mode = 0;
        send(5'h03);
        first = last_acc;
        send(5'h05);
        send(5'h07);
        wait_out(base + 3, 50);
        checks++;
        if (got_q.size() !== base + 3) begin
            errors++; $display("FAIL lit_count: got %0d samples expected %0d", got_q.size() - base, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL lit_data[%0d]: got %0d expected %0d", i, got_q[base+i], exp[i]);
                end
            end
            checks++;
            if (got_cyc[base] !== first) begin
                errors++; $display("FAIL lit_latency: first sample cycle %0d expected %0d", got_cyc[base], first);
            end
            checks++;
            if (got_cyc[base+2] !== got_cyc[base] + 2) begin
                errors++; $display("FAIL lit_b2b: last sample cycle %0d expected %0d", got_cyc[base+2], got_cyc[base] + 2);
            end
        end
    endtask

    task automatic test_run3();
        int base = got_q.size();
        int bb = busy_cnt;
        int ib = ir_low_cnt;
        logic [DATA_W-1:0] exp [4] = '{3'd0, 3'd0, 3'd0, 3'd2};
        or_mode = 0;
        send(5'h13);
        send(5'h02);
        wait_out(base + 4, 50);
        checks++;
        if (got_q.size() !== base + 4) begin
            errors++; $display("FAIL run3_count: got %0d samples expected 4", got_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL run3_data[%0d]: got %0d expected %0d", i, got_q[base+i], exp[i]);
                end
            end
            checks++;
            if (got_cyc[base+3] !== got_cyc[base] + 3) begin
                errors++; $display("FAIL run3_bubble: literal cycle %0d expected %0d", got_cyc[base+3], got_cyc[base] + 3);
            end
        end
        checks++; if (busy_cnt - bb !== 2) begin errors++; $display("FAIL run3_busy: got %0d cycles expected 2", busy_cnt - bb); end
        checks++; if (ir_low_cnt - ib !== 2) begin errors++; $display("FAIL run3_i_r: got %0d low cycles expected 2", ir_low_cnt - ib); end
    endtask

    task automatic test_run15();
        int base = got_q.size();
        int ob = overlap_cnt;
        or_mode = 1;
        send(5'h1F);
        send(5'h01);
        wait_out(base + 16, 200);
        checks++;
        if (got_q.size() !== base + 16) begin
            errors++; $display("FAIL run15_count: got %0d samples expected 16", got_q.size() - base);
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (got_q[base+i] !== 3'd0) begin
                    errors++; $display("FAIL run15_zero[%0d]: got %0d expected 0", i, got_q[base+i]);
                end
            end
            checks++;
            if (got_q[base+15] !== 3'd1) begin
                errors++; $display("FAIL run15_next: got %0d expected 1", got_q[base+15]);
            end
        end
        checks++; if (overlap_cnt - ob !== 0) begin errors++; $display("FAIL run15_accept_busy: got %0d cycles expected 0", overlap_cnt - ob); end
        or_mode = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_lit_zero();
        int base = got_q.size();
        or_mode = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL litz_err_before: got %b expected 0", err); end
        send(5'h0D);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL litz_err_upper: got %b expected 0", err); end
        send(5'h00);
        wait_out(base + 2, 50);
        checks++;
        if (got_q.size() !== base + 2) begin
            errors++; $display("FAIL litz_count: got %0d samples expected 2", got_q.size() - base);
        end else begin
            checks++; if (got_q[base] !== 3'd5) begin errors++; $display("FAIL litz_upper: got %0d expected 5", got_q[base]); end
            checks++; if (got_q[base+1] !== 3'd0) begin errors++; $display("FAIL litz_data: got %0d expected 0", got_q[base+1]); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL litz_err: got %b expected 1", err); end
    endtask

    task automatic test_reset_midrun();
        int base;
        or_mode = 0;
        send(5'h1F);
        repeat (7) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL mid_o_v: got %b expected 0", o_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL mid_i_r: got %b expected 1", i_r); end
        base = got_q.size();
        send(5'h06);
        wait_out(base + 1, 50);
        checks++;
        if (got_q.size() !== base + 1) begin
            errors++; $display("FAIL mid_count: got %0d samples expected 1", got_q.size() - base);
        end else if (got_q[base] !== 3'd6) begin
            errors++; $display("FAIL mid_data: got %0d expected 6", got_q[base]);
        end
    endtask

    task automatic test_run1_zero();
        int base = got_q.size();
        or_mode = 0;
        send(5'h11);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rz_err_n1: got %b expected 0", err); end
        send(5'h10);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rz_err_n0: got %b expected 1", err); end
        send(5'h04);
        wait_out(base + 2, 50);
        checks++;
        if (got_q.size() !== base + 2) begin
            errors++; $display("FAIL rz_count: got %0d samples expected 2", got_q.size() - base);
        end else begin
            checks++; if (got_q[base] !== 3'd0) begin errors++; $display("FAIL rz_data0: got %0d expected 0", got_q[base]); end
            checks++; if (got_q[base+1] !== 3'd4) begin errors++; $display("FAIL rz_data1: got %0d expected 4", got_q[base+1]); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rz_err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] samples[$];
        logic [CNT_W:0]    tokens[$];
        int                zrun = 0;
        int                base;
        int                bad = 0;
        for (int s = 0; s < 50; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                int len = $urandom_range(1, 20);
                for (int z = 0; z < len; z++) samples.push_back(3'd0);
            end else begin
                samples.push_back(3'($urandom_range(1, 7)));
            end
        end
        // Reference encoder: runs capped at 15, nonzero samples as literals.
        foreach (samples[i]) begin
            if (samples[i] == 3'd0) begin
                zrun++;
                if (zrun == 15) begin
                    tokens.push_back({1'b1, 4'd15});
                    zrun = 0;
                end
            end else begin
                if (zrun > 0) tokens.push_back({1'b1, 4'(zrun)});
                zrun = 0;
                tokens.push_back({2'b00, samples[i]});
            end
        end
        if (zrun > 0) tokens.push_back({1'b1, 4'(zrun)});

        base = got_q.size();
        or_mode = 2;
        foreach (tokens[i]) send(tokens[i]);
        wait_out(base + samples.size(), 4000);
        or_mode = 0;
        checks++;
        if (got_q.size() !== base + samples.size()) begin
            errors++; $display("FAIL rand_count: got %0d samples expected %0d", got_q.size() - base, samples.size());
        end else begin
            foreach (samples[i]) begin
                checks++;
                if (got_q[base+i] !== samples[i]) begin
                    errors++;
                    if (bad < 5) $display("FAIL rand_data[%0d]: got %0d expected %0d", i, got_q[base+i], samples[i]);
                    bad++;
                end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    initial begin : main
        test_reset();
        test_literals();
        test_run3();
        test_run15();
        test_lit_zero();
        test_reset_midrun();
        test_run1_zero();
        test_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
